// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the ALU issue controller: opcode/funct7 encodings,
// ALU op codes, FSM states and decode helpers.
package alu_issue_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLTU = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b0110,
        ALU_AND  = 4'b1000,
        ALU_OR   = 4'b1001,
        ALU_XOR  = 4'b1010
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB,
        ST_ERR
    } state_e;

    // funct3 -> ALU op; alt selects SUB/SRA on the two funct3 codes that have a variant.
    function automatic alu_op_e f3_to_op(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Fetch-handshake, regfile and ALU signals of the issue controller, bundled as one interface.
interface alu_issue_ctrl_if;
    import alu_issue_ctrl_pkg::*;

    logic            i_instr_vld;
    logic            o_instr_rdy;
    logic [XLEN-1:0] i_instr;
    logic [4:0]      o_rs1_addr;
    logic [4:0]      o_rs2_addr;
    logic [XLEN-1:0] i_rs1_data;
    logic [XLEN-1:0] i_rs2_data;
    logic [XLEN-1:0] o_operand_a;
    logic [XLEN-1:0] o_operand_b;
    logic [3:0]      o_alu_op;
    logic [XLEN-1:0] i_alu_data;
    logic [4:0]      o_rd_addr;
    logic [XLEN-1:0] o_rd_data;
    logic            o_rd_wren;
    logic            o_illegal;

    modport master (
        input  i_instr_vld, i_instr, i_rs1_data, i_rs2_data, i_alu_data,
        output o_instr_rdy, o_rs1_addr, o_rs2_addr, o_operand_a, o_operand_b,
               o_alu_op, o_rd_addr, o_rd_data, o_rd_wren, o_illegal
    );

    modport slave (
        output i_instr_vld, i_instr, i_rs1_data, i_rs2_data, i_alu_data,
        input  o_instr_rdy, o_rs1_addr, o_rs2_addr, o_operand_a, o_operand_b,
               o_alu_op, o_rd_addr, o_rd_data, o_rd_wren, o_illegal
    );

endinterface

// File: rtl/alu_issue_ctrl_decoder.sv
// Combinational RV32I OP/OP-IMM decoder: ALU op, operand-B source, immediate and legality.
module alu_decoder
    import alu_issue_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] instr_i,
    output alu_op_e         alu_op_o,
    output logic            use_imm_o,
    output logic            is_shift_imm_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_reg_fields;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm_o  = sext12(instr_i[31:20]);

    // Register specifiers are routed by the top, not needed for decode.
    assign unused_reg_fields = ^{instr_i[19:15], instr_i[11:7]};

    always_comb begin
        alu_op_o       = ALU_ADD;
        use_imm_o      = 1'b0;
        is_shift_imm_o = 1'b0;
        illegal_o      = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    alu_op_o = f3_to_op(funct3, 1'b0);
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    alu_op_o = f3_to_op(funct3, 1'b1);
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_OPIMM: begin
                use_imm_o = 1'b1;
                case (funct3)
                    3'b001: begin
                        is_shift_imm_o = 1'b1;
                        alu_op_o       = ALU_SLL;
                        illegal_o      = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        is_shift_imm_o = 1'b1;
                        if (funct7 == F7_BASE) begin
                            alu_op_o = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            alu_op_o = ALU_SRA;
                        end else begin
                            illegal_o = 1'b1;
                        end
                    end
                    default: alu_op_o = f3_to_op(funct3, 1'b0);
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller: accepts one OP/OP-IMM instruction, reads the regfile,
// drives the single-cycle ALU and writes the result back (IDLE->READ->EXEC->WB).
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    alu_issue_ctrl_if.master bus
);

    state_e          state_q, state_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [4:0]      rd_q, rd_d;
    alu_op_e         op_pend_q, op_pend_d;
    logic            use_imm_q, use_imm_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;
    alu_op_e         alu_op_q, alu_op_d;
    logic [XLEN-1:0] result_q, result_d;

    alu_op_e         dec_alu_op;
    logic            dec_use_imm;
    logic            dec_is_shift_imm;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    alu_decoder u_decoder (
        .instr_i        (bus.i_instr),
        .alu_op_o       (dec_alu_op),
        .use_imm_o      (dec_use_imm),
        .is_shift_imm_o (dec_is_shift_imm),
        .imm_o          (dec_imm),
        .illegal_o      (dec_illegal)
    );

    // Decode happens at the handshake; the operand-B immediate is resolved then
    // (shamt zero-extended vs. imm sign-extended) so READ only has to pick imm or rs2.
    always_comb begin
        state_d   = state_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        op_pend_d = op_pend_q;
        use_imm_d = use_imm_q;
        imm_d     = imm_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        alu_op_d  = alu_op_q;
        result_d  = result_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_instr_vld) begin
                    state_d   = dec_illegal ? ST_ERR : ST_READ;
                    rs1_d     = bus.i_instr[19:15];
                    rs2_d     = bus.i_instr[24:20];
                    rd_d      = bus.i_instr[11:7];
                    op_pend_d = dec_alu_op;
                    use_imm_d = dec_use_imm;
                    imm_d     = dec_is_shift_imm ? {{(XLEN-5){1'b0}}, dec_imm[4:0]} : dec_imm;
                end
            end
            ST_READ: begin
                state_d  = ST_EXEC;
                opa_d    = bus.i_rs1_data;
                opb_d    = use_imm_q ? imm_q : bus.i_rs2_data;
                alu_op_d = op_pend_q;
            end
            ST_EXEC: begin
                state_d  = ST_WB;
                result_d = bus.i_alu_data;
            end
            ST_WB:   state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            op_pend_q <= ALU_ADD;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            alu_op_q  <= ALU_ADD;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            op_pend_q <= op_pend_d;
            use_imm_q <= use_imm_d;
            imm_q     <= imm_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            alu_op_q  <= alu_op_d;
            result_q  <= result_d;
        end
    end

    assign bus.o_instr_rdy = (state_q == ST_IDLE);
    assign bus.o_rs1_addr  = rs1_q;
    assign bus.o_rs2_addr  = rs2_q;
    assign bus.o_operand_a = opa_q;
    assign bus.o_operand_b = opb_q;
    assign bus.o_alu_op    = alu_op_q;
    assign bus.o_rd_addr   = rd_q;
    assign bus.o_rd_data   = result_q;
    assign bus.o_rd_wren   = (state_q == ST_WB) && (rd_q != 5'd0);
    assign bus.o_illegal   = (state_q == ST_ERR);

endmodule
